// File: rtl/eth_40gb_pkg.sv
// Shared types and constants for the 40GbE QSFP port.
package eth_40gb_pkg;

  localparam int unsigned LANES_40G = 4;
  localparam int unsigned RETRY_W   = 4;

  typedef enum logic [2:0] {
    NO_MOD     = 3'd0,
    MOD_RST    = 3'd1,
    MOD_INIT   = 3'd2,
    PHY_RST    = 3'd3,
    WAIT_READY = 3'd4,
    WAIT_LOCK  = 3'd5,
    LINK_UP    = 3'd6,
    FAULT      = 3'd7
  } link_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/qsfp_link_ctrl.sv
// QSFP link bring-up sequencer: module sideband, PHY reset, lane qualification,
// timeout/retry and debounced link_up. Optional statistics: QSFP_LINK_STATS_EN.
module qsfp_link_ctrl
  import eth_40gb_pkg::*;
#(
  parameter int unsigned LANES           = LANES_40G,
  parameter int unsigned MOD_RST_CYCLES  = 512,
  parameter int unsigned MOD_INIT_CYCLES = 65536,
  parameter int unsigned PHY_RST_CYCLES  = 64,
  parameter int unsigned READY_TIMEOUT   = 1048576,
  parameter int unsigned LOCK_STABLE     = 1024,
  parameter int unsigned MAX_RETRIES     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mod_prsn,
  input  logic [LANES-1:0]   tx_ready,
  input  logic [LANES-1:0]   rx_ready,
  input  logic [LANES-1:0]   rx_blk_lock,
  input  logic [LANES-1:0]   rx_highber,
  input  logic               restart,
  output logic               qsfp_rstn,
  output logic               qsfp_lp_mode,
  output logic               qsfp_mod_seln,
  output logic               phy_reset,
  output logic               link_up,
  output logic               fault,
  output link_state_t        state,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef QSFP_LINK_STATS_EN
  ,
  output logic [15:0]        link_drop_cnt,
  output logic [LANES-1:0]   lane_lock_lost
`endif
);

  localparam int unsigned PH_MAX = max_u(max_u(MOD_RST_CYCLES, MOD_INIT_CYCLES), PHY_RST_CYCLES);
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam int unsigned ST_W   = $clog2(LOCK_STABLE + 1);
  localparam int unsigned TO_W   = $clog2(READY_TIMEOUT + 1);

  localparam logic [PH_W-1:0]    MOD_RST_LAST  = PH_W'(MOD_RST_CYCLES - 1);
  localparam logic [PH_W-1:0]    MOD_INIT_LAST = PH_W'(MOD_INIT_CYCLES - 1);
  localparam logic [PH_W-1:0]    PHY_RST_LAST  = PH_W'(PHY_RST_CYCLES - 1);
  localparam logic [ST_W-1:0]    STABLE_LAST   = ST_W'(LOCK_STABLE - 1);
  localparam logic [TO_W-1:0]    TMO_LAST      = TO_W'(READY_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM     = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_SAT     = {RETRY_W{1'b1}};

  link_state_t        state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [ST_W-1:0]    stable_q, stable_d;
  logic [TO_W-1:0]    tmo_q, tmo_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic               rstn_q, rstn_d, lp_q, lp_d, seln_q, seln_d;
  logic               phyrst_q, phyrst_d, linkup_q, linkup_d, fault_q, fault_d;
  logic               all_ok, phy_rdy, tmo_hit, clr_stats;

  // Lane qualification and timeout/retry helpers.
  always_comb begin
    all_ok    = &(tx_ready & rx_ready & rx_blk_lock & ~rx_highber);
    phy_rdy   = &(tx_ready & rx_ready);
    tmo_hit   = (tmo_q == TMO_LAST);
    retry_inc = (retry_q == RETRY_SAT) ? retry_q : retry_q + RETRY_W'(1);
  end

  // Next state and counters; removal beats restart, restart beats everything else.
  always_comb begin
    state_d   = state_q;
    phase_d   = '0;
    stable_d  = '0;
    tmo_d     = '0;
    retry_d   = retry_q;
    clr_stats = 1'b0;
    case (state_q)
      NO_MOD:   state_d = MOD_RST;
      MOD_RST: begin
        phase_d = phase_q + PH_W'(1);
        if (phase_q == MOD_RST_LAST) state_d = MOD_INIT;
      end
      MOD_INIT: begin
        phase_d = phase_q + PH_W'(1);
        if (phase_q == MOD_INIT_LAST) state_d = PHY_RST;
      end
      PHY_RST: begin
        phase_d = phase_q + PH_W'(1);
        if (phase_q == PHY_RST_LAST) state_d = WAIT_READY;
      end
      WAIT_READY: begin
        tmo_d = tmo_q + TO_W'(1);
        if (phy_rdy) begin
          state_d = WAIT_LOCK;
        end else if (tmo_hit) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_LIM) ? FAULT : PHY_RST;
        end
      end
      WAIT_LOCK: begin
        tmo_d    = tmo_q + TO_W'(1);
        stable_d = all_ok ? stable_q + ST_W'(1) : '0;
        if (all_ok && (stable_q == STABLE_LAST)) begin
          state_d = LINK_UP;
          retry_d = '0;
        end else if (tmo_hit) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_LIM) ? FAULT : PHY_RST;
        end
      end
      LINK_UP:  if (!all_ok) state_d = PHY_RST;
      FAULT:    state_d = FAULT;
      default:  state_d = NO_MOD;
    endcase
    if (state_d != state_q) begin
      phase_d  = '0;
      stable_d = '0;
    end
    if ((state_d != WAIT_READY) && (state_d != WAIT_LOCK)) tmo_d = '0;
    if (restart && (state_q != NO_MOD)) begin
      state_d   = MOD_RST;
      phase_d   = '0;
      stable_d  = '0;
      tmo_d     = '0;
      retry_d   = '0;
      clr_stats = 1'b1;
    end
    if (mod_prsn) begin
      state_d   = NO_MOD;
      phase_d   = '0;
      stable_d  = '0;
      tmo_d     = '0;
      retry_d   = retry_q;
      clr_stats = 1'b0;
    end
  end

  // Sideband/status levels for the state being entered.
  always_comb begin
    rstn_d   = 1'b1;
    lp_d     = 1'b0;
    seln_d   = 1'b0;
    phyrst_d = 1'b0;
    linkup_d = 1'b0;
    fault_d  = 1'b0;
    case (state_d)
      NO_MOD, MOD_RST: begin
        rstn_d   = 1'b0;
        lp_d     = 1'b1;
        seln_d   = 1'b1;
        phyrst_d = 1'b1;
      end
      MOD_INIT, PHY_RST: phyrst_d = 1'b1;
      LINK_UP:           linkup_d = 1'b1;
      FAULT: begin
        phyrst_d = 1'b1;
        fault_d  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef QSFP_LINK_STATS_EN
  localparam int unsigned DROP_W = 16;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [LANES-1:0]  lost_q, lost_d;

  // Saturating drop counter and sticky per-lane lock-loss while up.
  always_comb begin
    drop_d = drop_q;
    lost_d = lost_q;
    if (state_q == LINK_UP) lost_d = lost_q | ~rx_blk_lock;
    if ((state_q == LINK_UP) && (state_d == PHY_RST) && (drop_q != {DROP_W{1'b1}}))
      drop_d = drop_q + DROP_W'(1);
    if (clr_stats) begin
      drop_d = '0;
      lost_d = '0;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
      lost_q <= '0;
    end else begin
      drop_q <= drop_d;
      lost_q <= lost_d;
    end
  end

  assign link_drop_cnt  = drop_q;
  assign lane_lock_lost = lost_q;
`endif

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= NO_MOD;
      phase_q  <= '0;
      stable_q <= '0;
      tmo_q    <= '0;
      retry_q  <= '0;
      rstn_q   <= 1'b0;
      lp_q     <= 1'b1;
      seln_q   <= 1'b1;
      phyrst_q <= 1'b1;
      linkup_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      stable_q <= stable_d;
      tmo_q    <= tmo_d;
      retry_q  <= retry_d;
      rstn_q   <= rstn_d;
      lp_q     <= lp_d;
      seln_q   <= seln_d;
      phyrst_q <= phyrst_d;
      linkup_q <= linkup_d;
      fault_q  <= fault_d;
    end
  end

  assign qsfp_rstn     = rstn_q;
  assign qsfp_lp_mode  = lp_q;
  assign qsfp_mod_seln = seln_q;
  assign phy_reset     = phyrst_q;
  assign link_up       = linkup_q;
  assign fault         = fault_q;
  assign state         = state_q;
  assign retry_cnt     = retry_q;

endmodule

// File: tb/tb_qsfp_link_ctrl.sv
// Bench for qsfp_link_ctrl with shortened timings; directed scenarios plus a
// randomized run against a dwell-time reference model. Optional: QSFP_LINK_STATS_EN.
module tb_qsfp_link_ctrl;
  import eth_40gb_pkg::*;

  localparam int LANES = 4;
  localparam int MRC = 4, MIC = 8, PRC = 2, RTO = 50, LS = 5, MR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, mod_prsn = 1'b1, restart = 1'b0;
  logic [LANES-1:0] tx_ready = '1, rx_ready = '1, rx_blk_lock = '1, rx_highber = '0;
  logic qsfp_rstn, qsfp_lp_mode, qsfp_mod_seln, phy_reset, link_up, fault;
  link_state_t state;
  logic [3:0] retry_cnt;
`ifdef QSFP_LINK_STATS_EN
  logic [15:0] link_drop_cnt;
  logic [LANES-1:0] lane_lock_lost;
`endif

  qsfp_link_ctrl #(
    .LANES(LANES), .MOD_RST_CYCLES(MRC), .MOD_INIT_CYCLES(MIC), .PHY_RST_CYCLES(PRC),
    .READY_TIMEOUT(RTO), .LOCK_STABLE(LS), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .reset(reset), .mod_prsn(mod_prsn), .tx_ready(tx_ready), .rx_ready(rx_ready),
    .rx_blk_lock(rx_blk_lock), .rx_highber(rx_highber), .restart(restart),
    .qsfp_rstn(qsfp_rstn), .qsfp_lp_mode(qsfp_lp_mode), .qsfp_mod_seln(qsfp_mod_seln),
    .phy_reset(phy_reset), .link_up(link_up), .fault(fault), .state(state),
    .retry_cnt(retry_cnt)
`ifdef QSFP_LINK_STATS_EN
    , .link_drop_cnt(link_drop_cnt), .lane_lock_lost(lane_lock_lost)
`endif
  );

  int n_ok = 0, n_chk = 0;

  // Reference model: state name, cycles already spent in it, cycles spent in the
  // ready/lock window, length of the current all-good run.
  link_state_t m_st = NO_MOD;
  int m_dwell = 0, m_win = 0, m_run = 0, m_retry = 0, m_drops = 0;
  logic [LANES-1:0] m_lost = '0;

  task automatic model_step();
    link_state_t nx;
    bit ok, rdy, tmo, rs;
    if (reset) begin
      m_st = NO_MOD; m_dwell = 0; m_win = 0; m_run = 0;
      m_retry = 0; m_drops = 0; m_lost = '0;
      return;
    end
    ok = 1; rdy = 1; tmo = 0; rs = 0;
    for (int l = 0; l < LANES; l++) begin
      if (!(tx_ready[l] && rx_ready[l])) begin rdy = 0; ok = 0; end
      if (!rx_blk_lock[l] || rx_highber[l]) ok = 0;
    end
    nx = m_st;
    if (m_st == LINK_UP) m_lost = m_lost | ~rx_blk_lock;
    if (mod_prsn) nx = NO_MOD;
    else if (restart && m_st != NO_MOD) begin
      nx = MOD_RST; rs = 1; m_retry = 0; m_drops = 0; m_lost = '0;
    end else begin
      case (m_st)
        NO_MOD:     nx = MOD_RST;
        MOD_RST:    if (m_dwell + 1 == MRC) nx = MOD_INIT;
        MOD_INIT:   if (m_dwell + 1 == MIC) nx = PHY_RST;
        PHY_RST:    if (m_dwell + 1 == PRC) nx = WAIT_READY;
        WAIT_READY: if (rdy) nx = WAIT_LOCK; else tmo = (m_win + 1 == RTO);
        WAIT_LOCK: begin
          m_run = ok ? m_run + 1 : 0;
          if (m_run == LS) nx = LINK_UP; else tmo = (m_win + 1 == RTO);
        end
        LINK_UP: if (!ok) begin nx = PHY_RST; if (m_drops < 65535) m_drops++; end
        default: ;
      endcase
      if (tmo) begin
        if (m_retry < 15) m_retry++;
        nx = (m_retry == MR) ? FAULT : PHY_RST;
      end
      if (nx == LINK_UP && m_st != LINK_UP) m_retry = 0;
    end
    m_win = ((nx inside {WAIT_READY, WAIT_LOCK}) && (m_st inside {WAIT_READY, WAIT_LOCK})) ? m_win + 1 : 0;
    if (nx != WAIT_LOCK) m_run = 0;
    m_dwell = (nx == m_st && !rs) ? m_dwell + 1 : 0;
    m_st = nx;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic lanes_good();
    tx_ready = '1; rx_ready = '1; rx_blk_lock = '1; rx_highber = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mod_prsn = 1'b1; restart = 1'b0; lanes_good();
    tick(); tick();
    n_chk++;
    if ({qsfp_rstn, qsfp_lp_mode, qsfp_mod_seln, phy_reset, link_up, fault} !== 6'b011100)
      $display("FAIL reset_outputs: got %b want 011100",
               {qsfp_rstn, qsfp_lp_mode, qsfp_mod_seln, phy_reset, link_up, fault});
    else n_ok++;
    n_chk++;
    if (state !== NO_MOD) $display("FAIL reset_state: got %0d want %0d", state, NO_MOD); else n_ok++;
    n_chk++;
    if (retry_cnt !== 4'd0) $display("FAIL reset_retry: got %0d want 0", retry_cnt); else n_ok++;
    reset = 1'b0;
    tick();
    n_chk++;
    if (state !== NO_MOD) $display("FAIL absent_idle: got %0d want %0d", state, NO_MOD); else n_ok++;
  endtask

  task automatic test_nominal();
    int rstn_low = 0, phy_hi = 0, phy_st = 0, t = 0, t_wl = -1, t_lu = -1;
    mod_prsn = 1'b0;
    while (t_lu < 0 && t < 200) begin
      tick(); t++;
      if (!qsfp_rstn) rstn_low++;
      if (phy_reset) phy_hi++;
      if (state == PHY_RST) phy_st++;
      if (state == WAIT_LOCK && t_wl < 0) t_wl = t;
      if (link_up) t_lu = t;
    end
    n_chk++;
    if (t_lu < 0) $display("FAIL nominal_linkup: got no link_up in %0d cycles want link_up", t); else n_ok++;
    n_chk++;
    if (rstn_low != MRC) $display("FAIL nominal_rstn_width: got %0d want %0d", rstn_low, MRC); else n_ok++;
    n_chk++;
    if (phy_st != PRC) $display("FAIL nominal_phy_rst_cycles: got %0d want %0d", phy_st, PRC); else n_ok++;
    n_chk++;
    if (phy_hi != MRC + MIC + PRC)
      $display("FAIL nominal_phy_reset_high: got %0d want %0d", phy_hi, MRC + MIC + PRC);
    else n_ok++;
    n_chk++;
    if (t_lu - t_wl != LS) $display("FAIL nominal_lock_latency: got %0d want %0d", t_lu - t_wl, LS); else n_ok++;
    n_chk++;
    if (retry_cnt !== 4'd0) $display("FAIL nominal_retry: got %0d want 0", retry_cnt); else n_ok++;
  endtask

  task automatic test_link_loss();
    logic [3:0] r_before;
    r_before = 4'(m_retry);
    n_chk++;
    if (state !== LINK_UP) $display("FAIL loss_precond: got %0d want %0d", state, LINK_UP); else n_ok++;
    rx_highber[1] = 1'b1;
    tick();
    rx_highber[1] = 1'b0;
    n_chk++;
    if (link_up !== 1'b0) $display("FAIL loss_link_up: got %b want 0", link_up); else n_ok++;
    n_chk++;
    if (state !== PHY_RST) $display("FAIL loss_state: got %0d want %0d", state, PHY_RST); else n_ok++;
    n_chk++;
    if (retry_cnt !== r_before) $display("FAIL loss_retry: got %0d want %0d", retry_cnt, r_before); else n_ok++;
  endtask

  task automatic test_lock_glitch();
    int t = 0;
    while (state != WAIT_LOCK && t < 50) begin tick(); t++; end
    n_chk++;
    if (state !== WAIT_LOCK) $display("FAIL glitch_reach_lock: got %0d want %0d", state, WAIT_LOCK); else n_ok++;
    repeat (3) tick();
    rx_blk_lock[2] = 1'b0;
    tick();
    rx_blk_lock[2] = 1'b1;
    t = 4;
    while (!link_up && t < 50) begin tick(); t++; end
    n_chk++;
    if (t != LS + 4) $display("FAIL glitch_lock_latency: got %0d want %0d", t, LS + 4); else n_ok++;
  endtask

  task automatic test_timeout_fault();
    int t = 0, t1 = -1, t2 = -1, tf = -1;
    rx_ready = '0;
    while (tf < 0 && t < 400) begin
      tick(); t++;
      if (retry_cnt == 4'd1 && t1 < 0) t1 = t;
      if (retry_cnt == 4'd2 && t2 < 0) t2 = t;
      if (state == FAULT) tf = t;
    end
    n_chk++;
    if (t1 != 1 + PRC + RTO) $display("FAIL tmo_first_retry: got %0d want %0d", t1, 1 + PRC + RTO); else n_ok++;
    n_chk++;
    if (t2 - t1 != PRC + RTO) $display("FAIL tmo_second_retry: got %0d want %0d", t2 - t1, PRC + RTO); else n_ok++;
    n_chk++;
    if (tf - t2 != PRC + RTO) $display("FAIL tmo_fault_time: got %0d want %0d", tf - t2, PRC + RTO); else n_ok++;
    n_chk++;
    if ({fault, retry_cnt} !== {1'b1, 4'(MR)})
      $display("FAIL tmo_fault_flags: got fault=%b retry=%0d want fault=1 retry=%0d", fault, retry_cnt, MR);
    else n_ok++;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_chk++;
    if ({state, retry_cnt, fault} !== {MOD_RST, 4'd0, 1'b0})
      $display("FAIL restart_from_fault: got state=%0d retry=%0d fault=%b want state=%0d retry=0 fault=0",
               state, retry_cnt, fault, MOD_RST);
    else n_ok++;
  endtask

  task automatic test_removal();
    int t = 0;
    lanes_good();
    while (state != WAIT_LOCK && t < 100) begin tick(); t++; end
    n_chk++;
    if (state !== WAIT_LOCK) $display("FAIL removal_reach_lock: got %0d want %0d", state, WAIT_LOCK); else n_ok++;
    mod_prsn = 1'b1;
    tick();
    n_chk++;
    if ({state, qsfp_rstn, phy_reset, link_up} !== {NO_MOD, 1'b0, 1'b1, 1'b0})
      $display("FAIL removal_outputs: got state=%0d rstn=%b phy=%b up=%b want state=0 rstn=0 phy=1 up=0",
               state, qsfp_rstn, phy_reset, link_up);
    else n_ok++;
    mod_prsn = 1'b0;
    t = 0;
    while (!link_up && t < 100) begin tick(); t++; end
    n_chk++;
    if (t != 1 + MRC + MIC + PRC + 1 + LS)
      $display("FAIL removal_resequence: got %0d want %0d", t, 1 + MRC + MIC + PRC + 1 + LS);
    else n_ok++;
  endtask

`ifdef QSFP_LINK_STATS_EN
  task automatic test_stats();
    int t;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      while (!link_up && t < 100) begin tick(); t++; end
      n_chk++;
      if (!link_up) $display("FAIL stats_linkup%0d: got 0 want 1", k); else n_ok++;
      if (k < 2) begin
        rx_blk_lock[0] = 1'b0;
        tick();
        rx_blk_lock[0] = 1'b1;
      end
    end
    n_chk++;
    if (link_drop_cnt !== 16'd2) $display("FAIL stats_drop_cnt: got %0d want 2", link_drop_cnt); else n_ok++;
    n_chk++;
    if (lane_lock_lost !== 4'b0001) $display("FAIL stats_lock_lost: got %b want 0001", lane_lock_lost); else n_ok++;
  endtask
`endif

  task automatic test_random();
    int mode = 1, rem_left = 0, idx;
    logic [12:0] got, exp;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) mode = $urandom_range(0, 3);
      lanes_good();
      if (mode == 0) rx_ready = '0;
      if ($urandom_range(0, 19) == 0) begin
        idx = $urandom_range(0, LANES - 1);
        case ($urandom_range(0, 2))
          0: rx_blk_lock[idx] = 1'b0;
          1: rx_highber[idx]  = 1'b1;
          default: tx_ready[idx] = 1'b0;
        endcase
      end
      restart = ($urandom_range(0, 299) == 0);
      if (rem_left > 0) begin
        mod_prsn = 1'b1; rem_left--;
      end else if ($urandom_range(0, 499) == 0) begin
        mod_prsn = 1'b1; rem_left = $urandom_range(0, 3);
      end else mod_prsn = 1'b0;
      tick();
      got = {state, link_up, fault, retry_cnt, qsfp_rstn, qsfp_lp_mode, qsfp_mod_seln, phy_reset};
      exp = {m_st, m_st == LINK_UP, m_st == FAULT, 4'(m_retry),
             !(m_st inside {NO_MOD, MOD_RST}), m_st inside {NO_MOD, MOD_RST},
             m_st inside {NO_MOD, MOD_RST}, !(m_st inside {WAIT_READY, WAIT_LOCK, LINK_UP})};
      n_chk++;
      if (got !== exp) $display("FAIL rand_cycle%0d: got %h want %h", c, got, exp); else n_ok++;
`ifdef QSFP_LINK_STATS_EN
      n_chk++;
      if ({link_drop_cnt, lane_lock_lost} !== {16'(m_drops), m_lost})
        $display("FAIL rand_stats%0d: got %0d/%b want %0d/%b", c, link_drop_cnt, lane_lock_lost, m_drops, m_lost);
      else n_ok++;
`endif
    end
    restart = 1'b0;
    mod_prsn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_link_loss();
    test_lock_glitch();
    test_timeout_fault();
    test_removal();
`ifdef QSFP_LINK_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
